// File: rtl/phys_free_list_pkg.sv
// Shared sizing and types for the physical register free list, the
// physical register file and the rename map.
package phys_free_list_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS);
  localparam int NUM_FREE      = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int IDX_W         = $clog2(NUM_FREE);
  // One extra wrap bit separates a full list from an empty one.
  localparam int PTR_W         = IDX_W + 1;

  typedef logic [LOG_PHYS-1:0] phys_tag_t;
  typedef logic [PTR_W-1:0]    fl_ptr_t;
endpackage

// File: rtl/phys_free_list.sv
// Physical tag free list: a circular FIFO with a speculative head (rename),
// a committed head (retire) and a tail (tags released by retire).
// A flush rewinds the speculative head to the committed head in one cycle.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic                Alloc_Req_IN,
  output logic                Alloc_Valid_OUT,
  output logic [LOG_PHYS-1:0] Alloc_Reg_OUT,
  output logic                BusyBit_Rename_Valid_OUT,
  output logic [LOG_PHYS-1:0] BusyBit_Rename_OUT,
  input  logic                Commit_IN,
  input  logic                Free_Valid_IN,
  input  logic [LOG_PHYS-1:0] Free_Reg_IN,
  input  logic                Flush_IN,
  output logic [PTR_W-1:0]    Free_Count_OUT,
  output logic                Error_OUT
);

  phys_tag_t fifo_q [NUM_FREE];
  fl_ptr_t   head_q, head_d;
  fl_ptr_t   chead_q, chead_d;
  fl_ptr_t   tail_q, tail_d;
  logic      err_q, err_d;
  logic      busy_v_q;
  phys_tag_t busy_tag_q;

  logic grant, commit_err, commit_ok, overflow, free_ok;

  // Grant, commit and free qualification, plus next pointer values.
  always_comb begin
    Alloc_Valid_OUT = (tail_q != head_q) && !Flush_IN;
    Alloc_Reg_OUT   = fifo_q[head_q[IDX_W-1:0]];
    Free_Count_OUT  = tail_q - head_q;
    grant      = Alloc_Req_IN && Alloc_Valid_OUT && !STALL;
    // Retiring more than was allocated is a protocol error; drop it.
    commit_err = Commit_IN && (chead_q == head_q);
    commit_ok  = Commit_IN && !commit_err;
    // Without a same-cycle commit the list cannot hold another entry.
    overflow   = Free_Valid_IN && !Commit_IN &&
                 ((tail_q - chead_q) == fl_ptr_t'(NUM_FREE));
    free_ok    = Free_Valid_IN && !overflow;
    chead_d    = chead_q + {{(PTR_W-1){1'b0}}, commit_ok};
    // Flush includes a commit landing in the same cycle; grant is 0 then.
    head_d     = Flush_IN ? chead_d : head_q + {{(PTR_W-1){1'b0}}, grant};
    tail_d     = tail_q + {{(PTR_W-1){1'b0}}, free_ok};
    err_d      = err_q | commit_err | overflow;
  end

  // Pointer, error and busy-pulse registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q     <= '0;
      chead_q    <= '0;
      tail_q     <= fl_ptr_t'(NUM_FREE);
      err_q      <= 1'b0;
      busy_v_q   <= 1'b0;
      busy_tag_q <= '0;
    end else begin
      head_q   <= head_d;
      chead_q  <= chead_d;
      tail_q   <= tail_d;
      err_q    <= err_d;
      busy_v_q <= grant;
      if (grant) busy_tag_q <= Alloc_Reg_OUT;
    end
  end

  // Tag storage; reset loads the tags not used by the architectural map.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_FREE; i++)
        fifo_q[i] <= phys_tag_t'(NUM_ARCH_REGS + i);
    end else if (free_ok) begin
      fifo_q[tail_q[IDX_W-1:0]] <= Free_Reg_IN;
    end
  end

  assign BusyBit_Rename_Valid_OUT = busy_v_q;
  assign BusyBit_Rename_OUT       = busy_tag_q;
  assign Error_OUT                = err_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios plus a randomized run, all
// checked against a queue-based model (available tags / uncommitted tags).
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic            CLK = 1'b0, RESET = 1'b1, STALL = 1'b0, Alloc_Req_IN = 1'b0;
  logic            Commit_IN = 1'b0, Free_Valid_IN = 1'b0, Flush_IN = 1'b0;
  phys_tag_t       Free_Reg_IN = '0;
  logic            Alloc_Valid_OUT, BusyBit_Rename_Valid_OUT, Error_OUT;
  phys_tag_t       Alloc_Reg_OUT, BusyBit_Rename_OUT;
  logic [PTR_W-1:0] Free_Count_OUT;

  int checks = 0, errors = 0;

  // Model: tags available in allocation order, tags allocated but not retired.
  phys_tag_t avail[$], spec[$];
  bit        m_err, m_busy_v;
  phys_tag_t m_busy_tag;
  // Comb outputs observed inside the stepped cycle, before the edge.
  logic      pre_valid;
  phys_tag_t pre_reg;

  phys_free_list dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .Alloc_Req_IN(Alloc_Req_IN),
    .Alloc_Valid_OUT(Alloc_Valid_OUT), .Alloc_Reg_OUT(Alloc_Reg_OUT),
    .BusyBit_Rename_Valid_OUT(BusyBit_Rename_Valid_OUT),
    .BusyBit_Rename_OUT(BusyBit_Rename_OUT), .Commit_IN(Commit_IN),
    .Free_Valid_IN(Free_Valid_IN), .Free_Reg_IN(Free_Reg_IN),
    .Flush_IN(Flush_IN), .Free_Count_OUT(Free_Count_OUT), .Error_OUT(Error_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    avail.delete(); spec.delete();
    for (int i = 0; i < NUM_FREE; i++) avail.push_back(phys_tag_t'(NUM_ARCH_REGS + i));
    m_err = 0; m_busy_v = 0; m_busy_tag = '0;
  endtask

  task automatic model_step(input bit req, stall, commit, fv, input phys_tag_t ftag,
                            input bit flush);
    bit grant, c_ok, ovf;
    phys_tag_t g, rest[$];
    int total;
    total = avail.size() + spec.size();
    grant = req && (avail.size() > 0) && !flush && !stall;
    c_ok  = commit && (spec.size() > 0);
    ovf   = fv && !commit && (total == NUM_FREE);
    if ((commit && !c_ok) || ovf) m_err = 1;
    m_busy_v = grant;
    if (grant) begin
      g = avail.pop_front();
      m_busy_tag = g;
    end
    if (c_ok) void'(spec.pop_front());
    if (grant) spec.push_back(g);
    if (flush) begin
      rest = avail;
      avail = spec;
      foreach (rest[k]) avail.push_back(rest[k]);
      spec.delete();
    end
    if (fv && !ovf) avail.push_back(ftag);
  endtask

  // One clock cycle: drive, observe comb outputs, clock, go idle at negedge.
  task automatic step(input bit req, stall = 0, commit = 0, fv = 0,
                      input phys_tag_t ftag = '0, input bit flush = 0);
    Alloc_Req_IN = req; STALL = stall; Commit_IN = commit;
    Free_Valid_IN = fv; Free_Reg_IN = ftag; Flush_IN = flush;
    #1;
    pre_valid = Alloc_Valid_OUT; pre_reg = Alloc_Reg_OUT;
    model_step(req, stall, commit, fv, ftag, flush);
    @(posedge CLK); #1;
    Alloc_Req_IN = 0; STALL = 0; Commit_IN = 0; Free_Valid_IN = 0; Flush_IN = 0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1; #2; RESET = 0;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Alloc_Valid_OUT !== 1'b1) begin errors++; $display("FAIL reset_valid got %0d exp 1", Alloc_Valid_OUT); end
    checks++; if (Alloc_Reg_OUT !== 6'd32) begin errors++; $display("FAIL reset_reg got %0d exp 32", Alloc_Reg_OUT); end
    checks++; if (Free_Count_OUT !== 6'd32) begin errors++; $display("FAIL reset_count got %0d exp 32", Free_Count_OUT); end
    checks++; if (BusyBit_Rename_Valid_OUT !== 1'b0 || Error_OUT !== 1'b0) begin errors++;
      $display("FAIL reset_flags got busy %0d err %0d exp 0 0", BusyBit_Rename_Valid_OUT, Error_OUT); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 33; i++) begin
      step(1);
      if (i < 32) begin
        checks++; if (pre_valid !== 1'b1 || pre_reg !== phys_tag_t'(32 + i)) begin errors++;
          $display("FAIL drain_alloc[%0d] got v%0d tag %0d exp v1 tag %0d", i, pre_valid, pre_reg, 32 + i); end
        checks++; if (BusyBit_Rename_Valid_OUT !== 1'b1 || BusyBit_Rename_OUT !== phys_tag_t'(32 + i)) begin errors++;
          $display("FAIL drain_busy[%0d] got v%0d tag %0d exp v1 tag %0d", i, BusyBit_Rename_Valid_OUT, BusyBit_Rename_OUT, 32 + i); end
      end else begin
        checks++; if (pre_valid !== 1'b0 || Free_Count_OUT !== 6'd0 || BusyBit_Rename_Valid_OUT !== 1'b0) begin errors++;
          $display("FAIL drain_empty got v%0d cnt %0d busy %0d exp 0 0 0", pre_valid, Free_Count_OUT, BusyBit_Rename_Valid_OUT); end
      end
    end
  endtask

  // Runs right after test_drain: list empty, 32 uncommitted tags.
  task automatic test_free_no_bypass();
    step(1, 0, 1, 1, 6'd40);
    checks++; if (pre_valid !== 1'b0 || BusyBit_Rename_Valid_OUT !== 1'b0) begin errors++;
      $display("FAIL nobypass_same got v%0d busy %0d exp 0 0", pre_valid, BusyBit_Rename_Valid_OUT); end
    checks++; if (Alloc_Valid_OUT !== 1'b1 || Alloc_Reg_OUT !== 6'd40) begin errors++;
      $display("FAIL nobypass_next got v%0d tag %0d exp v1 tag 40", Alloc_Valid_OUT, Alloc_Reg_OUT); end
    step(1);
    checks++; if (BusyBit_Rename_Valid_OUT !== 1'b1 || BusyBit_Rename_OUT !== 6'd40) begin errors++;
      $display("FAIL nobypass_busy got v%0d tag %0d exp v1 tag 40", BusyBit_Rename_Valid_OUT, BusyBit_Rename_OUT); end
  endtask

  task automatic test_flush();
    do_reset();
    repeat (3) step(1);
    step(0, 0, 1);
    step(0, 0, 0, 0, '0, 1);
    checks++; if (Free_Count_OUT !== 6'd31 || Alloc_Reg_OUT !== 6'd33) begin errors++;
      $display("FAIL flush_state got cnt %0d tag %0d exp cnt 31 tag 33", Free_Count_OUT, Alloc_Reg_OUT); end
    step(1);
    checks++; if (BusyBit_Rename_Valid_OUT !== 1'b1 || BusyBit_Rename_OUT !== 6'd33) begin errors++;
      $display("FAIL flush_regrant got v%0d tag %0d exp v1 tag 33", BusyBit_Rename_Valid_OUT, BusyBit_Rename_OUT); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (32) step(1);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 1, phys_tag_t'(i));
    checks++; if (Free_Count_OUT !== 6'd32) begin errors++;
      $display("FAIL wrap_count got %0d exp 32", Free_Count_OUT); end
    for (int i = 0; i < 32; i++) begin
      step(1);
      checks++; if (BusyBit_Rename_Valid_OUT !== 1'b1 || BusyBit_Rename_OUT !== phys_tag_t'(i)) begin errors++;
        $display("FAIL wrap_alloc[%0d] got v%0d tag %0d exp v1 tag %0d", i, BusyBit_Rename_Valid_OUT, BusyBit_Rename_OUT, i); end
    end
    checks++; if (Error_OUT !== 1'b0) begin errors++; $display("FAIL wrap_err got %0d exp 0", Error_OUT); end
  endtask

  task automatic test_violations();
    do_reset();
    step(0, 0, 0, 1, 6'd5);
    checks++; if (Error_OUT !== 1'b1 || Free_Count_OUT !== 6'd32) begin errors++;
      $display("FAIL overflow got err %0d cnt %0d exp err 1 cnt 32", Error_OUT, Free_Count_OUT); end
    step(1);
    checks++; if (BusyBit_Rename_OUT !== 6'd32 || Error_OUT !== 1'b1) begin errors++;
      $display("FAIL overflow_alloc got tag %0d err %0d exp tag 32 err 1", BusyBit_Rename_OUT, Error_OUT); end
    do_reset();
    step(0, 0, 1);
    checks++; if (Error_OUT !== 1'b1) begin errors++; $display("FAIL bad_commit got err %0d exp 1", Error_OUT); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    repeat (3) step(1, 1);
    checks++; if (BusyBit_Rename_Valid_OUT !== 1'b0 || Alloc_Reg_OUT !== 6'd32 || Free_Count_OUT !== 6'd32) begin errors++;
      $display("FAIL stall got busy %0d tag %0d cnt %0d exp 0 32 32", BusyBit_Rename_Valid_OUT, Alloc_Reg_OUT, Free_Count_OUT); end
    repeat (10) step(1);
    checks++; if (BusyBit_Rename_Valid_OUT !== 1'b1 || BusyBit_Rename_OUT !== 6'd41) begin errors++;
      $display("FAIL pre_reset_busy got v%0d tag %0d exp v1 tag 41", BusyBit_Rename_Valid_OUT, BusyBit_Rename_OUT); end
    RESET = 1; #1;
    checks++; if (BusyBit_Rename_Valid_OUT !== 1'b0 || Alloc_Reg_OUT !== 6'd32 || Free_Count_OUT !== 6'd32) begin errors++;
      $display("FAIL mid_reset got busy %0d tag %0d cnt %0d exp 0 32 32", BusyBit_Rename_Valid_OUT, Alloc_Reg_OUT, Free_Count_OUT); end
    RESET = 0;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_random();
    bit req, stall, commit, fv, flush;
    phys_tag_t tag;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req    = ($urandom % 4) != 0;
      stall  = ($urandom % 5) == 0;
      commit = ($urandom % 3) == 0 && (spec.size() > 0 || ($urandom % 40) == 0);
      flush  = ($urandom % 16) == 0;
      fv     = ($urandom % 3) == 0;
      tag    = phys_tag_t'($urandom_range(0, NUM_PHYS_REGS - 1));
      // A release with an unmatched commit while full has no defined result.
      if (commit && spec.size() == 0 && avail.size() == NUM_FREE) fv = 0;
      step(req, stall, commit, fv, tag, flush);
      checks++;
      if (Alloc_Valid_OUT !== (avail.size() > 0) ||
          (avail.size() > 0 && Alloc_Reg_OUT !== avail[0]) ||
          Free_Count_OUT !== PTR_W'(avail.size()) ||
          BusyBit_Rename_Valid_OUT !== m_busy_v ||
          (m_busy_v && BusyBit_Rename_OUT !== m_busy_tag) ||
          Error_OUT !== m_err) begin
        errors++;
        $display("FAIL random[%0d] got v%0d tag %0d cnt %0d busy %0d/%0d err %0d exp v%0d tag %0d cnt %0d busy %0d/%0d err %0d",
                 n, Alloc_Valid_OUT, Alloc_Reg_OUT, Free_Count_OUT, BusyBit_Rename_Valid_OUT,
                 BusyBit_Rename_OUT, Error_OUT, avail.size() > 0,
                 (avail.size() > 0) ? avail[0] : phys_tag_t'(0), avail.size(),
                 m_busy_v, m_busy_tag, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_drain();
    test_free_no_bypass();
    test_flush();
    test_wrap();
    test_violations();
    test_stall_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
